axi_lite_mem_slave: RTL and testbench
=====================================

AXI_LITE_MEM_SLAVE -- requirements
Module: axi_lite_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values are 32 or 64.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, word count; must be a power of two and at least 2.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of word 0; must be aligned to MEM_DEPTH*DATA_WIDTH/8.
REQ-005 SHALL have ports clk (input, 1, clock) and rst (input, 1, synchronous active-high reset), listed first.
REQ-006 SHALL have awaddr (in, ADDR_WIDTH), awvalid (in, 1) and awready (out, 1): write address channel.
REQ-007 SHALL have wdata (in, DATA_WIDTH), wstrb (in, DATA_WIDTH/8), wvalid (in, 1) and wready (out, 1): write data channel.
REQ-008 SHALL have bresp (out, 2), bvalid (out, 1) and bready (in, 1): write response channel.
REQ-009 SHALL have araddr (in, ADDR_WIDTH), arvalid (in, 1) and arready (out, 1): read address channel.
REQ-010 SHALL have rdata (out, DATA_WIDTH), rresp (out, 2), rvalid (out, 1) and rready (in, 1): read data channel.
REQ-011 SHALL use one clock, clk, with reset rst synchronous and active-high.

Function
REQ-012 SHALL buffer AW and W independently in one-entry holding registers: aw_held and w_held.
REQ-013 SHALL drive awready = !aw_held && !rst and wready = !w_held && !rst; both are combinational from registers only.
REQ-014 SHALL accept AW and W in either order or in the same cycle; an accepted beat stays held until its write commits.
REQ-015 SHALL commit a write at the first edge where aw_held && w_held && !bvalid.
REQ-016 At commit: write each byte lane i where wstrb[i]=1, set bvalid=1, load bresp, and clear both held flags on the same edge.
REQ-017 SHALL hold bvalid and bresp stable until bvalid && bready, then clear bvalid; a held AW/W pair then commits on the next edge.
REQ-018 SHALL compute word index = ((addr - BASE_ADDR) >> log2(DATA_WIDTH/8)) modulo MEM_DEPTH.
REQ-019 SHALL drive arready = !rvalid && !rst.
REQ-020 On AR handshake at edge N: register rdata and rresp from araddr at edge N, and assert rvalid after edge N (1-cycle latency).
REQ-021 SHALL hold rvalid, rdata and rresp stable until rvalid && rready; the next AR may be accepted from the cycle after rvalid clears.
REQ-022 Read and write paths are independent; if a read and a write commit hit the same word on the same edge, the read SHALL return the pre-write data.
REQ-023 wstrb=0 SHALL commit with no memory change and still return a B response.

Reset
REQ-024 While rst=1: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0, and held flags cleared.
REQ-025 Reset asserted mid-transaction SHALL drop all held beats and pending responses without writing memory; memory contents are not reset.

Configuration
REQ-026 With AXIL_MEM_ERR_CHECK_EN defined: an address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*DATA_WIDTH/8) or not DATA_WIDTH/8-aligned gives SLVERR (2'b10); writes do not modify memory; reads return rdata=0.
REQ-027 Without AXIL_MEM_ERR_CHECK_EN: the address wraps per REQ-018, low offset bits are ignored, and bresp/rresp are always OKAY (2'b00).

Verification
REQ-028 Write 0x1000 data 0xDEADBEEF wstrb 0xF with AW and W in the same cycle; bvalid 2 cycles later with bresp=00; read 0x1000 returns 0xDEADBEEF with rvalid 1 cycle after AR.
REQ-029 W to 0x4 first (0x11223344, wstrb 0x5), AW 3 cycles later, over prior 0xFFFFFFFF; readback = 0xFF22FF44.
REQ-030 Hold bready=0 for 5 cycles after a write; bvalid stays high, a second AW/W pair is accepted but not committed; wready=0 until the commit that follows bready.
REQ-031 Same-edge read of word 3 and write commit of 0xA5A5A5A5 to word 3 (old value 0x0); read returns 0x0, and a subsequent read returns 0xA5A5A5A5.
REQ-032 With BASE_ADDR=0, DATA_WIDTH=32, MEM_DEPTH=256, and AXIL_MEM_ERR_CHECK_EN defined, access 0x400: bresp=10, memory unchanged, rresp=10 with rdata=0. Undefined: 0x400 aliases word 0 with OKAY.
REQ-033 Assert rst with AW held and rvalid pending; after release, all valids are 0 and the held write is never committed.

Source files
------------

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite word-addressed memory slave with independent read and write paths.
// Define AXIL_MEM_ERR_CHECK_EN to answer SLVERR on out-of-window or misaligned addresses.
module axi_lite_mem_slave #(
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter int unsigned              MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int unsigned Bytes = DATA_WIDTH / 8;
    localparam int unsigned OffW  = $clog2(Bytes);
    localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

`ifdef AXIL_MEM_ERR_CHECK_EN
    localparam bit ErrCheck = 1'b1;
`else
    localparam bit ErrCheck = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [Bytes-1:0]      w_strb_q;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic [IdxW-1:0]       aw_idx, ar_idx;
    logic                  aw_err, ar_err;
    logic                  commit;

    // Offsets relative to the window; base alignment makes offset alignment match address alignment
    assign aw_off = aw_addr_q - BASE_ADDR;
    assign ar_off = araddr - BASE_ADDR;
    assign aw_idx = aw_off[OffW +: IdxW];
    assign ar_idx = ar_off[OffW +: IdxW];
    assign aw_err = ErrCheck && ((aw_off[OffW-1:0] != '0) || ((aw_off >> (OffW + IdxW)) != '0));
    assign ar_err = ErrCheck && ((ar_off[OffW-1:0] != '0) || ((ar_off >> (OffW + IdxW)) != '0));

    assign commit  = aw_held_q && w_held_q && !bvalid_q;

    assign awready = !aw_held_q && !rst;
    assign wready  = !w_held_q && !rst;
    assign arready = !rvalid_q && !rst;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (wvalid && wready) begin
                w_held_q <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= aw_err ? RespSlvErr : RespOkay;
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
            end

            if (arvalid && arready) begin
                rvalid_q <= 1'b1;
                rresp_q  <= ar_err ? RespSlvErr : RespOkay;
                rdata_q  <= ar_err ? '0 : mem_q[ar_idx];
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Memory is deliberately not reset; a read on the commit edge sees the old word
    always_ff @(posedge clk) begin
        if (!rst && commit && !aw_err) begin
            for (int i = 0; i < Bytes; i++) begin
                if (w_strb_q[i]) begin
                    mem_q[aw_idx][8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed self-checking bench for axi_lite_mem_slave (default 32-bit, 256-word configuration).
module tb_axi_lite_mem_slave;

`ifdef AXIL_MEM_ERR_CHECK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    axi_lite_mem_slave dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] exp_resp);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, " held, no b yet"}, bvalid, 0);
        step();
        check({tag, " bvalid"}, bvalid, 1);
        check({tag, " bresp"}, bresp, exp_resp);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check({tag, " bvalid cleared"}, bvalid, 0);
    endtask

    task automatic read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
        araddr = addr; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check({tag, " rvalid"}, rvalid, 1);
        check({tag, " rdata"}, rdata, exp_data);
        check({tag, " rresp"}, rresp, exp_resp);
        check({tag, " arready low"}, arready, 0);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check({tag, " rvalid cleared"}, rvalid, 0);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        step();
        step();
        check("rst awready", awready, 0);
        check("rst wready", wready, 0);
        check("rst arready", arready, 0);
        check("rst bvalid", bvalid, 0);
        check("rst rvalid", rvalid, 0);
        check("rst rdata", rdata, 0);
        check("rst bresp", bresp, 0);
        check("rst rresp", rresp, 0);
        rst = 1'b0;
        #1;
        check("post-rst awready", awready, 1);
        check("post-rst wready", wready, 1);
        check("post-rst arready", arready, 1);

        // Same-cycle AW/W; 0x1000 is outside the 1 KiB window and aliases word 0
        write("wr 0x1000", 32'h1000, 32'hDEADBEEF, 4'hF, ErrEn ? 2'b10 : 2'b00);
        read("rd 0x1000", 32'h1000, ErrEn ? 32'h0 : 32'hDEADBEEF, ErrEn ? 2'b10 : 2'b00);

        // W leads AW by three cycles, partial strobes over all-ones
        write("wr 0x4 ones", 32'h4, 32'hFFFFFFFF, 4'hF, 2'b00);
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("w-first wready", wready, 0);
        check("w-first awready", awready, 1);
        check("w-first no b", bvalid, 0);
        step();
        step();
        awaddr = 32'h4; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("w-first pending", bvalid, 0);
        step();
        check("w-first bvalid", bvalid, 1);
        check("w-first bresp", bresp, 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        read("rd 0x4 strb", 32'h4, 32'hFF22FF44, 2'b00);

        // B back-pressure: second pair is held but cannot commit until B drains
        awaddr = 32'h8; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        check("bp first bvalid", bvalid, 1);
        awaddr = 32'hC; awvalid = 1'b1; wdata = 32'h2; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp bvalid held", bvalid, 1);
            check("bp wready low", wready, 0);
            check("bp awready low", awready, 0);
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bp b drained", bvalid, 0);
        check("bp still held", wready, 0);
        step();
        check("bp second bvalid", bvalid, 1);
        check("bp second commit wready", wready, 1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        read("rd 0x8", 32'h8, 32'h1, 2'b00);
        read("rd 0xC", 32'hC, 32'h2, 2'b00);

        // Read and commit to word 3 on the same edge: read sees the old value
        write("wr 0xC zero", 32'hC, 32'h0, 4'hF, 2'b00);
        awaddr = 32'hC; awvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'hC; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check("same-edge bvalid", bvalid, 1);
        check("same-edge rvalid", rvalid, 1);
        check("same-edge old data", rdata, 32'h0);
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0; rready = 1'b0;
        read("rd 0xC new", 32'hC, 32'hA5A5A5A5, 2'b00);

        // Zero strobe still responds but leaves memory alone
        write("wr 0x10", 32'h10, 32'h55, 4'hF, 2'b00);
        write("wr 0x10 strb0", 32'h10, 32'hAA, 4'h0, 2'b00);
        read("rd 0x10", 32'h10, 32'h55, 2'b00);

        // 0x400: alias of word 0 by default, SLVERR with error checking
        write("wr 0x0", 32'h0, 32'h0BADF00D, 4'hF, 2'b00);
        write("wr 0x400", 32'h400, 32'h12345678, 4'hF, ErrEn ? 2'b10 : 2'b00);
        read("rd 0x400", 32'h400, ErrEn ? 32'h0 : 32'h12345678, ErrEn ? 2'b10 : 2'b00);
        read("rd 0x0 alias", 32'h0, ErrEn ? 32'h0BADF00D : 32'h12345678, 2'b00);

        // Reset with AW held and a read response pending
        write("wr 0x14", 32'h14, 32'h1, 4'hF, 2'b00);
        awaddr = 32'h14; awvalid = 1'b1; araddr = 32'h10; arvalid = 1'b1;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        check("pre-rst rvalid", rvalid, 1);
        check("pre-rst aw held", awready, 0);
        rst = 1'b1;
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        #1;
        check("in-rst wready", wready, 0);
        step();
        check("in-rst rvalid", rvalid, 0);
        check("in-rst rdata", rdata, 0);
        check("in-rst bvalid", bvalid, 0);
        rst = 1'b0;
        step();
        wvalid = 1'b0;
        check("after-rst bvalid", bvalid, 0);
        check("after-rst rvalid", rvalid, 0);
        check("after-rst awready", awready, 1);
        step();
        check("dropped aw no commit", bvalid, 0);
        awaddr = 32'h18; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        step();
        check("post-rst commit bvalid", bvalid, 1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        read("rd 0x18", 32'h18, 32'h77, 2'b00);
        read("rd 0x14 untouched", 32'h14, 32'h1, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
